// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg: shared types and constants for the instruction prefetch queue.
// Holds the fetch-side request/response records, the NOP filler, the default
// buffer depth and the control-register record with its reset helper.
package prefetch_queue_pkg;

    localparam int unsigned PREFETCH_DEPTH_DEFAULT = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;     // current fetch PC
        logic [31:0] npc;    // redirect target
        logic        spec;   // speculation redirect (exception, mret, jump, clear)
        logic        valid;  // fetch stage consumes the presented instruction
        logic        fence;  // fence.i style flush
        logic [31:0] rdata;  // imem word for fpc
        logic        ready;  // rdata valid this cycle
    } prefetch_in_type;

    typedef struct packed {
        logic [31:0] instr;  // instruction at the head of the queue
        logic [31:0] fpc;    // word-aligned imem request address
        logic        stall;  // head instruction not yet complete
    } prefetch_out_type;

    // Control state that does not depend on the buffer depth.
    typedef struct packed {
        logic [31:0] fpc;
        logic        skip;   // drop low halfword of the next accepted word
    } prefetch_ctrl_type;

    function automatic prefetch_ctrl_type ctrl_init(logic [31:0] addr);
        prefetch_ctrl_type c;
        c.fpc  = addr & 32'hFFFF_FFFC;
        c.skip = addr[1];
        return c;
    endfunction

    // A halfword whose two low bits are 2'b11 starts a 32-bit encoding.
    function automatic logic is_rvi(logic [1:0] lo);
        return lo == 2'b11;
    endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// prefetch_queue_if: bundles the fetch-stage/imem request and response records.
// The queue sits on the slave side; the fetch/imem side drives the master side.
interface prefetch_queue_if;
    import prefetch_queue_pkg::*;

    prefetch_in_type  prefetch_in;
    prefetch_out_type prefetch_out;

    modport master (output prefetch_in, input prefetch_out);
    modport slave  (input prefetch_in, output prefetch_out);
endinterface

// File: rtl/prefetch_queue_ram.sv
// prefetch_ram: DEPTH x 16 halfword store for the prefetch queue.
// Two write ports (consecutive slots of one fetched word) and two
// combinational read ports (head halfword and the one after it).
module prefetch_ram
    import prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = PREFETCH_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we0_i,
    input  logic [$clog2(DEPTH)-1:0] waddr0_i,
    input  logic [15:0]              wdata0_i,
    input  logic                     we1_i,
    input  logic [$clog2(DEPTH)-1:0] waddr1_i,
    input  logic [15:0]              wdata1_i,
    input  logic [$clog2(DEPTH)-1:0] raddr0_i,
    output logic [15:0]              rdata0_o,
    input  logic [$clog2(DEPTH)-1:0] raddr1_i,
    output logic [15:0]              rdata1_o
);

    logic [15:0] mem_q [DEPTH];

    // Contents need no reset: occupancy is tracked by the queue's count.
    always_ff @(posedge clk) begin
        if (we0_i) mem_q[waddr0_i] <= wdata0_i;
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch queue between imem and the fetch stage.
// Fetches aligned words at its own pointer, buffers them as halfwords and
// presents the (16- or 32-bit) instruction at the head. Flushes on spec/fence.
// Optional feature macro: PREFETCH_BYPASS_EN (forward rdata straight to the
// fetch stage when the buffer is empty).
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = PREFETCH_DEPTH_DEFAULT,  // power of two, >= 4
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input logic             clk,
    input logic             rst,
    prefetch_queue_if.slave pf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam prefetch_ctrl_type CTRL_INIT = ctrl_init(RESET_ADDR);

    logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
    logic [PW-1:0]     rptr_p1, wptr_p1;
    logic [CW-1:0]     count_q, count_d;
    prefetch_ctrl_type ctrl_q, ctrl_d;

    prefetch_in_type   in_s;
    prefetch_out_type  out_s;

    logic [15:0]       h0, h1;
    logic              head_rvi, buf_stall, redirect, room, accept, bypass;
    logic              pop, we0, we1;
    logic [CW-1:0]     pop_n, push_n;
    logic [15:0]       wdata0;
    logic              unused_in;

    assign in_s      = pf.prefetch_in;
    assign unused_in = ^{in_s.pc, in_s.npc[0]};

    assign rptr_p1 = rptr_q + PW'(1);
    assign wptr_p1 = wptr_q + PW'(1);

    prefetch_ram #(.DEPTH(DEPTH)) u_ram (
        .clk      (clk),
        .we0_i    (we0),
        .waddr0_i (wptr_q),
        .wdata0_i (wdata0),
        .we1_i    (we1),
        .waddr1_i (wptr_p1),
        .wdata1_i (in_s.rdata[31:16]),
        .raddr0_i (rptr_q),
        .rdata0_o (h0),
        .raddr1_i (rptr_p1),
        .rdata1_o (h1)
    );

    assign head_rvi  = is_rvi(h0[1:0]);
    assign redirect  = in_s.spec | in_s.fence;
    assign buf_stall = (count_q == '0) | ((count_q == CW'(1)) & head_rvi);
    // Room is judged on occupancy before this cycle's pop.
    assign room      = (CW'(DEPTH) - count_q) >= CW'(2);
    assign accept    = in_s.ready & ~redirect & room;

`ifdef PREFETCH_BYPASS_EN
    assign bypass = (count_q == '0) & ~ctrl_q.skip & in_s.ready & ~redirect;
`else
    assign bypass = 1'b0;
`endif

    // Head decode, optional rdata bypass and write-lane steering.
    always_comb begin
        out_s.fpc   = ctrl_q.fpc;
        out_s.stall = buf_stall;
        out_s.instr = head_rvi ? {h1, h0} : {16'h0, h0};
        pop         = in_s.valid & ~buf_stall & ~redirect;
        pop_n       = head_rvi ? CW'(2) : CW'(1);
        we0         = accept;
        we1         = accept & ~ctrl_q.skip;
        wdata0      = ctrl_q.skip ? in_s.rdata[31:16] : in_s.rdata[15:0];

        // Empty buffer and an aligned word arriving: hand it over directly and
        // only store whatever the fetch stage did not consume.
        if (bypass) begin
            out_s.stall = 1'b0;
            pop         = 1'b0;
            if (is_rvi(in_s.rdata[1:0])) begin
                out_s.instr = in_s.rdata;
                if (in_s.valid) begin
                    we0 = 1'b0;
                    we1 = 1'b0;
                end
            end else begin
                out_s.instr = {16'h0, in_s.rdata[15:0]};
                if (in_s.valid) begin
                    we0    = 1'b1;
                    we1    = 1'b0;
                    wdata0 = in_s.rdata[31:16];
                end
            end
        end

        if (out_s.stall) out_s.instr = NOP;
        push_n = CW'(we0) + CW'(we1);
    end

    assign pf.prefetch_out = out_s;

    // Pointer, occupancy and fetch-pointer update; a redirect overrides everything.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ctrl_d  = ctrl_q;
        if (redirect) begin
            rptr_d      = '0;
            wptr_d      = '0;
            count_d     = '0;
            ctrl_d.fpc  = {in_s.npc[31:2], 2'b00};
            ctrl_d.skip = in_s.npc[1];
        end else begin
            if (pop) rptr_d = rptr_q + PW'(pop_n);
            wptr_d  = wptr_q + PW'(push_n);
            count_d = count_q + push_n - (pop ? pop_n : CW'(0));
            if (accept) begin
                ctrl_d.fpc  = ctrl_q.fpc + 32'd4;
                ctrl_d.skip = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ctrl_q  <= CTRL_INIT;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed vector table plus hand-written full-buffer and
// mid-run reset sequences for prefetch_queue (DEPTH=8, RESET_ADDR=0x100).
module tb_prefetch_queue;
    import prefetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    prefetch_queue_if pf ();

    prefetch_queue #(.DEPTH(8), .RESET_ADDR(32'h100)) dut (
        .clk (clk),
        .rst (rst),
        .pf  (pf)
    );

    typedef struct {
        logic        spec, fence, valid, ready;
        logic [31:0] rdata, npc;
        logic [31:0] e_instr;
        logic        e_stall;
        logic [31:0] e_fpc;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(logic s, logic f, logic v, logic r,
                                logic [31:0] rd, logic [31:0] np,
                                logic [31:0] ei, logic es, logic [31:0] ef);
        vec_t x;
        x.spec = s; x.fence = f; x.valid = v; x.ready = r;
        x.rdata = rd; x.npc = np;
        x.e_instr = ei; x.e_stall = es; x.e_fpc = ef;
        return x;
    endfunction

    task automatic drive(logic s, logic f, logic v, logic r, logic [31:0] rd, logic [31:0] np);
        pf.prefetch_in.pc    = 32'h0;
        pf.prefetch_in.spec  = s;
        pf.prefetch_in.fence = f;
        pf.prefetch_in.valid = v;
        pf.prefetch_in.ready = r;
        pf.prefetch_in.rdata = rd;
        pf.prefetch_in.npc   = np;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_out(string tag, logic [31:0] ei, logic es, logic [31:0] ef);
        check({tag, ".instr"}, pf.prefetch_out.instr, ei);
        check({tag, ".stall"}, {31'h0, pf.prefetch_out.stall}, {31'h0, es});
        check({tag, ".fpc"},   pf.prefetch_out.fpc, ef);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //               s  f  v  r  rdata         npc           exp instr     st exp fpc
        vecs[0]  = mk(0, 0, 0, 1, 32'h00A00093, 32'h0,        32'h00000013, 1, 32'h100);
        vecs[1]  = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00A00093, 0, 32'h104);
        vecs[2]  = mk(0, 0, 0, 1, 32'h45014581, 32'h0,        32'h00000013, 1, 32'h104);
        vecs[3]  = mk(0, 0, 1, 1, 32'h00A00093, 32'h0,        32'h00004581, 0, 32'h108);
        vecs[4]  = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00004501, 0, 32'h10C);
        vecs[5]  = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00A00093, 0, 32'h10C);
        vecs[6]  = mk(0, 0, 1, 1, 32'h00934501, 32'h0,        32'h00000013, 1, 32'h10C);
        vecs[7]  = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00004501, 0, 32'h110);
        vecs[8]  = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00000013, 1, 32'h110);
        vecs[9]  = mk(0, 0, 1, 1, 32'h000000A0, 32'h0,        32'h00000013, 1, 32'h110);
        vecs[10] = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00A00093, 0, 32'h114);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h00000000, 0, 32'h114);
        vecs[12] = mk(1, 0, 1, 1, 32'hDEADBEEF, 32'h202,      32'h00000000, 0, 32'h114);
        vecs[13] = mk(0, 0, 0, 1, 32'h45811111, 32'h0,        32'h00000013, 1, 32'h200);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h00004581, 0, 32'h204);
        vecs[15] = mk(1, 1, 1, 1, 32'h00A00093, 32'h300,      32'h00004581, 0, 32'h204);
        vecs[16] = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00000013, 1, 32'h300);
        vecs[17] = mk(0, 0, 0, 1, 32'h00A00093, 32'h0,        32'h00000013, 1, 32'h300);
        vecs[18] = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h00A00093, 0, 32'h304);
        vecs[19] = mk(0, 1, 0, 0, 32'h0,        32'h404,      32'h00000013, 1, 32'h304);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h00000013, 1, 32'h404);

        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("reset", 32'h00000013, 1'b1, 32'h100);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].spec, vecs[i].fence, vecs[i].valid, vecs[i].ready,
                  vecs[i].rdata, vecs[i].npc);
            #1;
            check_out($sformatf("v%0d", i), vecs[i].e_instr, vecs[i].e_stall, vecs[i].e_fpc);
        end

        // Fill to capacity: four words fit, later ready data is dropped and fpc holds.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 1, (32'(i) << 20) | 32'h93, 32'h0);
            #1;
            check($sformatf("full%0d.fpc", i), pf.prefetch_out.fpc,
                  32'h404 + 32'd4 * 32'((i < 4) ? i : 4));
            if (i > 0)
                check($sformatf("full%0d.instr", i), pf.prefetch_out.instr, 32'h00000093);
        end

        // Drain: exactly the four accepted words come out in order, then empty.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 0, 32'h0, 32'h0);
            #1;
            check_out($sformatf("drain%0d", k), (32'(k) << 20) | 32'h93, 1'b0, 32'h414);
        end
        @(negedge clk);
        drive(0, 0, 1, 0, 32'h0, 32'h0);
        #1;
        check_out("drained", 32'h00000013, 1'b1, 32'h414);

        // Reset in the middle of operation discards buffered data.
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h00A00093, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        check_out("prerst", 32'h00A00093, 1'b0, 32'h418);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("midrst", 32'h00000013, 1'b1, 32'h100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
